// File: rtl/core_mem_ctrl.sv
// Single-outstanding memory controller bridging core read/write requests onto a req/ack bus.
// Optional busy-timeout (o_mem_err, 8-bit counter) is compiled in with `define MEM_TIMEOUT_EN.
module core_mem_ctrl (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        ram_read,
  input  logic        ram_write,
  input  logic        ram_read_done,
  input  logic [15:0] addr,
  input  logic [15:0] wdata,
  output logic        mem_busy,
  output logic        mem_ready,
  output logic [15:0] rdata,
  output logic        o_req,
  output logic        o_we,
  output logic [15:0] o_addr,
  output logic [15:0] o_wdata,
  input  logic        i_ack,
  input  logic [15:0] i_rdata,
`ifdef MEM_TIMEOUT_EN
  output logic        o_mem_err,
`endif
  output logic [1:0]  o_state_dbg
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    READY = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic        we_q, we_d;
  logic [15:0] rdata_q, rdata_d;

`ifdef MEM_TIMEOUT_EN
  logic [7:0]  cnt_q, cnt_d;
  logic        err_q, err_d;
  logic        timeout;
`endif

  // Bus handshake: o_req is held high for the whole BUSY state with address,
  // data and direction frozen; the first cycle with i_ack=1 completes the transfer.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = we_q;
    rdata_d = rdata_q;
`ifdef MEM_TIMEOUT_EN
    timeout = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (ram_read) begin
          addr_d  = addr;
          we_d    = 1'b0;
          state_d = BUSY;
        end else if (ram_write) begin
          addr_d  = addr;
          wdata_d = wdata;
          we_d    = 1'b1;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (i_ack) begin
          if (we_q) begin
            state_d = IDLE;
          end else begin
            rdata_d = i_rdata;
            state_d = READY;
          end
        end
`ifdef MEM_TIMEOUT_EN
        // cnt_q counts prior BUSY cycles, so 254 marks the 255th without an ack.
        else if (cnt_q == 8'd254) begin
          timeout = 1'b1;
          if (we_q) begin
            state_d = IDLE;
          end else begin
            rdata_d = 16'hFFFF;
            state_d = READY;
          end
        end
`endif
      end
      READY: begin
        if (ram_read_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef MEM_TIMEOUT_EN
  always_comb begin
    cnt_d = 8'd0;
    err_d = timeout;
    if (state_q == BUSY && state_d == BUSY) cnt_d = cnt_q + 8'd1;
  end
`endif

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      addr_q  <= 16'd0;
      wdata_q <= 16'd0;
      we_q    <= 1'b0;
      rdata_q <= 16'd0;
`ifdef MEM_TIMEOUT_EN
      cnt_q   <= 8'd0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      rdata_q <= rdata_d;
`ifdef MEM_TIMEOUT_EN
      cnt_q   <= cnt_d;
      err_q   <= err_d;
`endif
    end
  end

  assign o_req       = (state_q == BUSY);
  assign mem_busy    = (state_q == BUSY);
  assign mem_ready   = (state_q == READY);
  assign o_we        = we_q;
  assign o_addr      = addr_q;
  assign o_wdata     = wdata_q;
  assign rdata       = rdata_q;
  assign o_state_dbg = state_q;
`ifdef MEM_TIMEOUT_EN
  assign o_mem_err   = err_q;
`endif

endmodule
